// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and widths for the SPI master
package spi_pkg;

  localparam int SPI_ADDR_W = 12;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    FIN
  } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SPI_CLK half-period generator with one-cycle rise/fall strobes
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic SysClk,
  input  logic Reset,
  input  logic en,
  output logic spi_clk,
  output logic riseStb,
  output logic fallStb
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase_end;

  // Strobes mark the SysClk edge on which spi_clk toggles.
  assign phase_end = en && (cnt == DIV_M1);
  assign riseStb   = phase_end && !spi_clk;
  assign fallStb   = phase_end && spi_clk;

  always_ff @(posedge SysClk) begin
    if (Reset || !en) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (cnt == DIV_M1) begin
      cnt     <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - SPI mode-0 master streaming tx memory out and rx bytes into rc memory
// SPIMASTER_LOOPBACK_EN: receive path samples internal MOSI instead of SPI_MISO.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ADDR_W   = SPI_ADDR_W,
  parameter int SS_GUARD = 2
) (
  input  logic                  SysClk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     xferLen,
  input  logic [ADDR_W-1:0]     txBase,
  input  logic [ADDR_W-1:0]     rcBase,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     txMemAddr,
  input  logic [SPI_BYTE_W-1:0] txMemData,
  output logic [ADDR_W-1:0]     rcMemAddr,
  output logic [SPI_BYTE_W-1:0] rcMemData,
  output logic                  rcMemWE,
  output logic                  SPI_CLK,
  output logic                  SPI_SS,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO
);

  localparam logic [7:0] GUARD_M1 = 8'(SS_GUARD - 1);

  spi_state_t            state;
  logic [ADDR_W-1:0]     len_r;
  logic [ADDR_W-1:0]     rc_base_r;
  logic [ADDR_W-1:0]     byte_idx;
  logic [7:0]            guard_cnt;
  logic [2:0]            bit_cnt;
  logic [SPI_BYTE_W-2:0] shreg;
  logic [SPI_BYTE_W-1:0] rxreg;
  logic                  rx_bit;
  logic                  riseStb;
  logic                  fallStb;

`ifdef SPIMASTER_LOOPBACK_EN
  assign rx_bit = SPI_MOSI;
`else
  assign rx_bit = SPI_MISO;
`endif

  spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .SysClk  (SysClk),
    .Reset   (Reset),
    .en      (state == SHIFT),
    .spi_clk (SPI_CLK),
    .riseStb (riseStb),
    .fallStb (fallStb)
  );

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      SPI_SS    <= 1'b1;
      SPI_MOSI  <= 1'b0;
      txMemAddr <= '0;
      rcMemAddr <= '0;
      rcMemData <= '0;
      rcMemWE   <= 1'b0;
      len_r     <= '0;
      rc_base_r <= '0;
      byte_idx  <= '0;
      guard_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rxreg     <= '0;
    end else begin
      done    <= 1'b0;
      rcMemWE <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_r     <= xferLen;
            rc_base_r <= rcBase;
            byte_idx  <= '0;
            guard_cnt <= '0;
            busy      <= 1'b1;
            if (xferLen != '0) begin
              state     <= LEAD;
              SPI_SS    <= 1'b0;
              txMemAddr <= txBase;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        LEAD: begin
          // First byte's read data is valid on the last guard cycle; prefetch the next.
          if (guard_cnt == GUARD_M1) begin
            shreg     <= txMemData[SPI_BYTE_W-2:0];
            SPI_MOSI  <= txMemData[SPI_BYTE_W-1];
            txMemAddr <= txMemAddr + 1'b1;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (riseStb) begin
            rxreg <= {rxreg[SPI_BYTE_W-2:0], rx_bit};
          end
          if (fallStb) begin
            if (bit_cnt != 3'd7) begin
              SPI_MOSI <= shreg[SPI_BYTE_W-2];
              shreg    <= {shreg[SPI_BYTE_W-3:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end else begin
              rcMemWE   <= 1'b1;
              rcMemData <= rxreg;
              rcMemAddr <= rc_base_r + byte_idx;
              bit_cnt   <= '0;
              if (byte_idx != len_r - 1'b1) begin
                byte_idx  <= byte_idx + 1'b1;
                shreg     <= txMemData[SPI_BYTE_W-2:0];
                SPI_MOSI  <= txMemData[SPI_BYTE_W-1];
                txMemAddr <= txMemAddr + 1'b1;
              end else begin
                guard_cnt <= '0;
                state     <= TRAIL;
              end
            end
          end
        end
        TRAIL: begin
          if (guard_cnt == GUARD_M1) begin
            SPI_SS <= 1'b1;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        FIN: begin
          busy     <= 1'b0;
          SPI_MOSI <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb/tb_spi_master_xfer.sv - randomized self-checking bench for spi_master_xfer with a mode-0 slave model
// SPIMASTER_LOOPBACK_EN selects CLK_DIV=1 and expects rc contents to mirror tx contents.
module tb_spi_master_xfer;

`ifdef SPIMASTER_LOOPBACK_EN
  localparam int TB_DIV = 1;
`else
  localparam int TB_DIV = 4;
`endif
  localparam int GUARD = 2;

  logic        SysClk = 1'b0;
  logic        Reset;
  logic        start;
  logic [11:0] xferLen, txBase, rcBase;
  logic        busy, done, rcMemWE;
  logic [11:0] txMemAddr, rcMemAddr;
  logic [7:0]  txMemData, rcMemData;
  logic        SPI_CLK, SPI_SS, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 SysClk = ~SysClk;

  spi_master_xfer #(
    .CLK_DIV  (TB_DIV),
    .ADDR_W   (12),
    .SS_GUARD (GUARD)
  ) dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .start     (start),
    .xferLen   (xferLen),
    .txBase    (txBase),
    .rcBase    (rcBase),
    .busy      (busy),
    .done      (done),
    .txMemAddr (txMemAddr),
    .txMemData (txMemData),
    .rcMemAddr (rcMemAddr),
    .rcMemData (rcMemData),
    .rcMemWE   (rcMemWE),
    .SPI_CLK   (SPI_CLK),
    .SPI_SS    (SPI_SS),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO)
  );

  // tx memory with one-cycle read latency
  logic [7:0] tx_mem [4096];
  always @(posedge SysClk) txMemData <= tx_mem[txMemAddr];

  // Monitors sampled on the falling SysClk edge
  int          cyc = 0, ss_low = 0, rises = 0, last_rise = 0, bad_spacing = 0, done_cnt = 0;
  logic        prev_clk = 1'b0;
  logic        mosi_q [$];
  logic [11:0] wa_q [$];
  logic [7:0]  wd_q [$];
  logic [11:0] ra_q [$];

  always @(negedge SysClk) begin
    cyc++;
    if (!SPI_SS) ss_low++;
    if (done) done_cnt++;
    if (SPI_CLK && !prev_clk) begin
      rises++;
      mosi_q.push_back(SPI_MOSI);
      if (rises > 1 && (cyc - last_rise) != 2 * TB_DIV) bad_spacing++;
      last_rise = cyc;
    end
    prev_clk = SPI_CLK;
    if (rcMemWE) begin
      wa_q.push_back(rcMemAddr);
      wd_q.push_back(rcMemData);
    end
    if (busy && (ra_q.size() == 0 || ra_q[$] != txMemAddr)) ra_q.push_back(txMemAddr);
  end

  // Mode-0 slave: presents MSB at SS fall, samples on rise, next bit after fall
  logic [7:0] resp_q [$];
  bit         echo = 1'b0;
  logic [7:0] s_cur = 8'h00, s_rx = 8'h00;
  int         s_bit = 0;
  logic       s_ss_d = 1'b1, s_clk_d = 1'b0;

  always @(SPI_SS or SPI_CLK) begin
    if (!SPI_SS && s_ss_d) begin
      s_bit = 0;
      s_cur = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      SPI_MISO = s_cur[7];
    end else if (!SPI_SS && SPI_CLK && !s_clk_d) begin
      s_rx = {s_rx[6:0], SPI_MOSI};
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        if (echo) resp_q.push_back(s_rx);
      end
    end else if (!SPI_SS && !SPI_CLK && s_clk_d) begin
      if (s_bit == 0) s_cur = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      SPI_MISO = s_cur[7 - s_bit];
    end
    s_ss_d  = SPI_SS;
    s_clk_d = SPI_CLK;
  end

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] resp);
`ifdef SPIMASTER_LOOPBACK_EN
    return tx;
`else
    return resp;
`endif
  endfunction

  task automatic tick();
    @(negedge SysClk);
    #1;
  endtask

  task automatic clear_mon();
    tick();
    ss_low = 0; rises = 0; bad_spacing = 0; done_cnt = 0;
    mosi_q.delete(); wa_q.delete(); wd_q.delete(); ra_q.delete();
  endtask

  // Issues one start, waits for done; lat counts cycles from the accepted start.
  task automatic run_xfer(input logic [11:0] len, input logic [11:0] txb, input logic [11:0] rcb,
                          output int lat, output int busy_low);
    int budget;
    budget = 2 * GUARD + 16 * TB_DIV * int'(len) + 40;
    clear_mon();
    start = 1'b1; xferLen = len; txBase = txb; rcBase = rcb;
    tick();
    start = 1'b0;
    lat = 1; busy_low = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    while (!done && lat < budget) begin
      if (!busy) busy_low++;
      tick();
      lat++;
    end
    total++;
    if (!done) begin bad++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_after_done: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; xferLen = '0; txBase = '0; rcBase = '0;
    repeat (3) tick();
    total++;
    if ({SPI_SS, SPI_CLK, SPI_MOSI, busy, done, rcMemWE} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: ss clk mosi busy done we = %b want 100000",
                      {SPI_SS, SPI_CLK, SPI_MOSI, busy, done, rcMemWE});
    end
    total++;
    if (txMemAddr !== 12'h0 || rcMemAddr !== 12'h0 || rcMemData !== 8'h0) begin
      bad++; $display("FAIL reset_addr: txa=%h rca=%h rcd=%h want 0", txMemAddr, rcMemAddr, rcMemData);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat, bl;
    logic [7:0] m;
    tx_mem[12'h010] = 8'hA5;
    echo = 1'b0; resp_q.delete(); resp_q.push_back(8'h3C);
    run_xfer(12'd1, 12'h010, 12'h100, lat, bl);
    m = 8'h00;
    foreach (mosi_q[i]) m = {m[6:0], mosi_q[i]};
    total++;
    if (mosi_q.size() != 8 || m !== 8'hA5) begin
      bad++; $display("FAIL single_mosi: got %h (%0d bits) want a5 (8 bits)", m, mosi_q.size());
    end
    total++;
    if (wa_q.size() != 1) begin
      bad++; $display("FAIL single_we_count: got %0d want 1", wa_q.size());
    end else if (wa_q[0] !== 12'h100 || wd_q[0] !== exp_rx(8'hA5, 8'h3C)) begin
      bad++; $display("FAIL single_write: got %h@%h want %h@100", wd_q[0], wa_q[0], exp_rx(8'hA5, 8'h3C));
    end
    total++;
    if (ss_low != 2 * GUARD + 16 * TB_DIV) begin
      bad++; $display("FAIL single_ss_low: got %0d want %0d", ss_low, 2 * GUARD + 16 * TB_DIV);
    end
    total++;
    if (lat != 2 * GUARD + 16 * TB_DIV + 1) begin
      bad++; $display("FAIL single_done_lat: got %0d want %0d", lat, 2 * GUARD + 16 * TB_DIV + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bl;
    logic [7:0] tx [3];
    logic [7:0] prev;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    for (int i = 0; i < 3; i++) tx_mem[12'h200 + i] = tx[i];
    echo = 1'b1; resp_q.delete();
    run_xfer(12'd3, 12'h200, 12'h300, lat, bl);
    echo = 1'b0;
    total++;
    if (rises != 24 || bad_spacing != 0) begin
      bad++; $display("FAIL b2b_clk: rises=%0d irregular=%0d want 24 0", rises, bad_spacing);
    end
    total++;
    if (bl != 0) begin bad++; $display("FAIL b2b_busy: low for %0d cycles want 0", bl); end
    total++;
    if (wa_q.size() != 3) begin
      bad++; $display("FAIL b2b_we_count: got %0d want 3", wa_q.size());
    end else begin
      prev = 8'h00;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wa_q[i] !== 12'h300 + 12'(i) || wd_q[i] !== exp_rx(tx[i], prev)) begin
          bad++; $display("FAIL b2b_byte%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i],
                          exp_rx(tx[i], prev), 12'h300 + 12'(i));
        end
        prev = tx[i];
      end
    end
  endtask

  task automatic test_wrap();
    int lat, bl;
    logic [7:0] t0, t1, r0, r1;
    t0 = 8'($urandom); t1 = 8'($urandom); r0 = 8'($urandom); r1 = 8'($urandom);
    tx_mem[12'hFFF] = t0; tx_mem[12'h000] = t1;
    echo = 1'b0; resp_q.delete(); resp_q.push_back(r0); resp_q.push_back(r1);
    run_xfer(12'd2, 12'hFFF, 12'hFFF, lat, bl);
    total++;
    if (ra_q.size() < 2 || ra_q[0] !== 12'hFFF || ra_q[1] !== 12'h000) begin
      bad++; $display("FAIL wrap_reads: first reads %h %h want fff 000",
                      (ra_q.size() > 0) ? ra_q[0] : 12'hxxx, (ra_q.size() > 1) ? ra_q[1] : 12'hxxx);
    end
    total++;
    if (wa_q.size() != 2 || wa_q[0] !== 12'hFFF || wa_q[1] !== 12'h000 ||
        wd_q[0] !== exp_rx(t0, r0) || wd_q[1] !== exp_rx(t1, r1)) begin
      bad++; $display("FAIL wrap_writes: %0d writes, want %h@fff %h@000",
                      wa_q.size(), exp_rx(t0, r0), exp_rx(t1, r1));
    end
  endtask

  task automatic test_len_zero();
    int lat, bl;
    run_xfer(12'd0, 12'h123, 12'h456, lat, bl);
    total++;
    if (lat != 1) begin bad++; $display("FAIL len0_done_lat: got %0d want 1", lat); end
    total++;
    if (ss_low != 0 || wa_q.size() != 0 || rises != 0) begin
      bad++; $display("FAIL len0_quiet: ss_low=%0d writes=%0d rises=%0d want 0 0 0",
                      ss_low, wa_q.size(), rises);
    end
  endtask

  task automatic test_ignore_and_reset();
    int n;
    logic [7:0] t0, r0;
    for (int i = 0; i < 3; i++) tx_mem[12'h400 + i] = 8'($urandom);
    t0 = tx_mem[12'h400]; r0 = 8'($urandom);
    echo = 1'b0; resp_q.delete(); resp_q.push_back(r0); resp_q.push_back(8'($urandom));
    clear_mon();
    start = 1'b1; xferLen = 12'd3; txBase = 12'h400; rcBase = 12'h500;
    tick();
    start = 1'b0;
    n = 0;
    while (rises < 3 && n < 400) begin tick(); n++; end
    start = 1'b1; xferLen = 12'd5; txBase = 12'h007; rcBase = 12'h600;
    tick();
    start = 1'b0;
    while (rises < 13 && n < 800) begin tick(); n++; end
    total++;
    if (rises < 13) begin bad++; $display("FAIL mid_progress: rises=%0d want 13", rises); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if (SPI_SS !== 1'b1 || SPI_CLK !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state: ss=%b clk=%b busy=%b want 1 0 0", SPI_SS, SPI_CLK, busy);
    end
    ss_low = 0;
    repeat (40) tick();
    total++;
    if (wa_q.size() != 1 || wa_q[0] !== 12'h500 || wd_q[0] !== exp_rx(t0, r0)) begin
      bad++; $display("FAIL mid_writes: %0d writes, want only %h@500", wa_q.size(), exp_rx(t0, r0));
    end
    total++;
    if (done_cnt != 0 || ss_low != 0) begin
      bad++; $display("FAIL mid_after_reset: done pulses=%0d ss_low=%0d want 0 0", done_cnt, ss_low);
    end
    foreach (ra_q[i]) begin
      total++;
      if (ra_q[i] < 12'h400 || ra_q[i] > 12'h402) begin
        bad++; $display("FAIL ignored_start_read: read %h outside 400..402", ra_q[i]);
      end
    end
  endtask

  task automatic test_random(input int iters);
    int lat, bl;
    logic [11:0] txb, rcb;
    logic [7:0] tx [4];
    logic [7:0] rs [4];
    for (int it = 0; it < iters; it++) begin
      txb = 12'($urandom); rcb = 12'($urandom);
      echo = 1'b0; resp_q.delete();
      for (int i = 0; i < 4; i++) begin
        tx[i] = 8'($urandom); rs[i] = 8'($urandom);
        tx_mem[txb + 12'(i)] = tx[i];
        resp_q.push_back(rs[i]);
      end
      run_xfer(12'd4, txb, rcb, lat, bl);
      total++;
      if (ss_low != 2 * GUARD + 64 * TB_DIV) begin
        bad++; $display("FAIL rand%0d_ss_low: got %0d want %0d", it, ss_low, 2 * GUARD + 64 * TB_DIV);
      end
      total++;
      if (wa_q.size() != 4) begin
        bad++; $display("FAIL rand%0d_we_count: got %0d want 4", it, wa_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          total++;
          if (wa_q[i] !== rcb + 12'(i) || wd_q[i] !== exp_rx(tx[i], rs[i])) begin
            bad++; $display("FAIL rand%0d_byte%0d: got %h@%h want %h@%h", it, i, wd_q[i], wa_q[i],
                            exp_rx(tx[i], rs[i]), rcb + 12'(i));
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_len_zero();
    test_ignore_and_reset();
    test_random(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
